i2s_tx: RTL

Output-side serializer for the audio path. It accepts the filter's 16-bit signed sample stream (`sample_in`/`sample_in_valid`, same one-cycle valid-strobe convention as the FIR output) and buffers it in a small FIFO. It transmits each sample as a 16-bit-per-slot, 32-BCLK I2S frame to the DAC, duplicating the mono sample into the left and right slots. It is the consumer end of the filter's sample interface and has no backpressure.

---
 rtl/i2s_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter: FIFO-buffered 16-bit samples, 32-BCLK frames, one-bit-delay framing.
// Define I2S_TX_UNDERFLOW_HOLD_EN to repeat the last sample on underflow frames instead of sending 0.
module i2s_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_in_valid,
  input  logic                          flag_clear,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic [4:0]    k_q, k_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic [31:0]   frame_q, frame_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
  logic [15:0]   last_q, last_d;
`endif

  logic        bclk_fall, load, empty, full, pop, push;
  logic [15:0] load_sample;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    bclk_d    = bclk_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end

    bclk_fall = (div_cnt_q == DIV_LAST) && bclk_q;
    load      = bclk_fall && (k_q == 5'd0);
    empty     = (count_q == '0);
    full      = (count_q == FULL_LVL);
    pop       = load && !empty;
    push      = sample_in_valid && (!full || pop);

`ifdef I2S_TX_UNDERFLOW_HOLD_EN
    load_sample = empty ? last_q : mem_q[rd_ptr_q];
    last_d      = load ? load_sample : last_q;
`else
    load_sample = empty ? '0 : mem_q[rd_ptr_q];
`endif

    // sdata always takes the MSB of the next frame value, so the load edge
    // emits the left MSB directly and each later fall shifts one bit out.
    k_d     = k_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    frame_d = frame_q;
    if (bclk_fall) begin
      k_d     = k_q + 5'd1;
      lrclk_d = k_d[4];
      frame_d = load ? {load_sample, load_sample} : {frame_q[30:0], 1'b0};
      sdata_d = frame_d[31];
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    ovf_d = (sample_in_valid && full && !pop) || (ovf_q && !flag_clear);
    udf_d = (load && empty) || (udf_q && !flag_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      k_q       <= '0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      frame_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
      last_q    <= '0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      k_q       <= k_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      frame_q   <= frame_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
      last_q    <= last_d;
`endif
    end
  end

  // Storage needs no reset: resetting the pointers and count discards contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign fifo_level = count_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule
